// File: rtl/cam_search_sched.sv
// Dual-lane search front-end for the dual-port ternary CAM.
// Two-stage pipeline (S1 key drive, S2 result capture) feeding a
// credit-protected in-order response FIFO with valid/ready backpressure.
module cam_search_sched #(
   parameter int DEPTH      = 64,
   parameter int WIDTH      = 36,
   parameter int ID_W       = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_0,
   input  logic [WIDTH-1:0] req_key_0,
   input  logic [ID_W-1:0]  req_id_0,
   output logic             req_ready_0,
   input  logic             req_valid_1,
   input  logic [WIDTH-1:0] req_key_1,
   input  logic [ID_W-1:0]  req_id_1,
   output logic             req_ready_1,
   output logic [WIDTH-1:0] mPatt_0,
   input  logic             match_0,
   input  logic [AW-1:0]    mAddr_0,
   output logic [WIDTH-1:0] mPatt_1,
   input  logic             match_1,
   input  logic [AW-1:0]    mAddr_1,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [ID_W-1:0]  resp_id,
   output logic             resp_hit,
   output logic [AW-1:0]    resp_addr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = CW + 1;
   localparam int EW = ID_W + 1 + AW;

   // S1 stage
   logic             s1_v0_q, s1_v0_d, s1_v1_q, s1_v1_d;
   logic [WIDTH-1:0] s1_key0_q, s1_key0_d, s1_key1_q, s1_key1_d;
   logic [ID_W-1:0]  s1_id0_q, s1_id0_d, s1_id1_q, s1_id1_d;

   // S2 stage
   logic             s2_v0_q, s2_v0_d, s2_v1_q, s2_v1_d;
   logic [ID_W-1:0]  s2_id0_q, s2_id0_d, s2_id1_q, s2_id1_d;
   logic             s2_hit0_q, s2_hit0_d, s2_hit1_q, s2_hit1_d;
   logic [AW-1:0]    s2_addr0_q, s2_addr0_d, s2_addr1_q, s2_addr1_d;

   // Response FIFO
   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [EW-1:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept_0, accept_1;
   logic             pop;
   logic [1:0]       n_push;
   logic [IW-1:0]    inflight, free_w;
   logic [EW-1:0]    head;

   // Credit accounting from registered occupancy only; accept decisions
   always_comb begin
      inflight = IW'(cnt_q)
               + IW'(s1_v0_q) + IW'(s1_v1_q)
               + IW'(s2_v0_q) + IW'(s2_v1_q);
      free_w      = IW'(FIFO_DEPTH) - inflight;
      req_ready_0 = (free_w >= IW'(1));
      req_ready_1 = (free_w >= IW'(2));
      accept_0    = req_valid_0 & req_ready_0;
      accept_1    = accept_0 & req_valid_1 & req_ready_1;
   end

   // S1 next state: keys only load on accept so mPatt holds when idle
   always_comb begin
      s1_v0_d   = accept_0;
      s1_v1_d   = accept_1;
      s1_key0_d = accept_0 ? req_key_0 : s1_key0_q;
      s1_id0_d  = accept_0 ? req_id_0  : s1_id0_q;
      s1_key1_d = accept_1 ? req_key_1 : s1_key1_q;
      s1_id1_d  = accept_1 ? req_id_1  : s1_id1_q;
   end

   assign mPatt_0 = s1_key0_q;
   assign mPatt_1 = s1_key1_q;

   // S2 next state: capture CAM result, address forced to zero on a miss
   always_comb begin
      s2_v0_d    = s1_v0_q;
      s2_v1_d    = s1_v1_q;
      s2_id0_d   = s1_id0_q;
      s2_id1_d   = s1_id1_q;
      s2_hit0_d  = match_0;
      s2_hit1_d  = match_1;
      s2_addr0_d = match_0 ? mAddr_0 : '0;
      s2_addr1_d = match_1 ? mAddr_1 : '0;
   end

   // FIFO next state: lane 0 pushed ahead of lane 1, one pop per cycle
   always_comb begin
      mem_d  = mem_q;
      n_push = {1'b0, s2_v0_q} + {1'b0, s2_v1_q};
      pop    = resp_valid & resp_ready;
      if (s2_v0_q) begin
         mem_d[wr_ptr_q] = {s2_id0_q, s2_hit0_q, s2_addr0_q};
      end
      if (s2_v1_q) begin
         mem_d[wr_ptr_q + PW'(s2_v0_q)] = {s2_id1_q, s2_hit1_q, s2_addr1_q};
      end
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(n_push) - CW'(pop);
   end

   // Response outputs are zeroed while the FIFO is empty
   always_comb begin
      resp_valid = (cnt_q != '0);
      head       = resp_valid ? mem_q[rd_ptr_q] : '0;
      {resp_id, resp_hit, resp_addr} = head;
   end

   // Pipeline and FIFO state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v0_q    <= 1'b0;
         s1_v1_q    <= 1'b0;
         s1_key0_q  <= '0;
         s1_key1_q  <= '0;
         s1_id0_q   <= '0;
         s1_id1_q   <= '0;
         s2_v0_q    <= 1'b0;
         s2_v1_q    <= 1'b0;
         s2_id0_q   <= '0;
         s2_id1_q   <= '0;
         s2_hit0_q  <= 1'b0;
         s2_hit1_q  <= 1'b0;
         s2_addr0_q <= '0;
         s2_addr1_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         s1_v0_q    <= s1_v0_d;
         s1_v1_q    <= s1_v1_d;
         s1_key0_q  <= s1_key0_d;
         s1_key1_q  <= s1_key1_d;
         s1_id0_q   <= s1_id0_d;
         s1_id1_q   <= s1_id1_d;
         s2_v0_q    <= s2_v0_d;
         s2_v1_q    <= s2_v1_d;
         s2_id0_q   <= s2_id0_d;
         s2_id1_q   <= s2_id1_d;
         s2_hit0_q  <= s2_hit0_d;
         s2_hit1_q  <= s2_hit1_d;
         s2_addr0_q <= s2_addr0_d;
         s2_addr1_q <= s2_addr1_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_cam_search_sched.sv
// Bench for cam_search_sched: behavioural CAM, queue-based scoreboard
// of outstanding requests, per-scenario tasks.
module tb_cam_search_sched;

   localparam int DEPTH      = 64;
   localparam int WIDTH      = 36;
   localparam int ID_W       = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int AW         = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid_0 = 1'b0, req_valid_1 = 1'b0;
   logic [WIDTH-1:0] req_key_0 = '0, req_key_1 = '0;
   logic [ID_W-1:0]  req_id_0 = '0, req_id_1 = '0;
   logic             req_ready_0, req_ready_1;
   logic [WIDTH-1:0] mPatt_0, mPatt_1;
   logic             match_0, match_1;
   logic [AW-1:0]    mAddr_0, mAddr_1;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [ID_W-1:0]  resp_id;
   logic             resp_hit;
   logic [AW-1:0]    resp_addr;

   always #5 clk = ~clk;

   cam_search_sched #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_key_0(req_key_0), .req_id_0(req_id_0), .req_ready_0(req_ready_0),
      .req_valid_1(req_valid_1), .req_key_1(req_key_1), .req_id_1(req_id_1), .req_ready_1(req_ready_1),
      .mPatt_0(mPatt_0), .match_0(match_0), .mAddr_0(mAddr_0),
      .mPatt_1(mPatt_1), .match_1(match_1), .mAddr_1(mAddr_1),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_hit(resp_hit), .resp_addr(resp_addr)
   );

   // CAM contents (static during the run)
   logic [WIDTH-1:0] cam_key [DEPTH];
   logic             cam_vld [DEPTH];

   function automatic logic [AW:0] lookup(input logic [WIDTH-1:0] k);
      for (int i = 0; i < DEPTH; i++) begin
         if (cam_vld[i] && cam_key[i] == k) return {1'b1, AW'(i)};
      end
      return '0;
   endfunction

   // Behavioural CAM; drives junk addresses on a miss
   logic [AW:0] lk0, lk1;
   always_comb begin
      lk0 = lookup(mPatt_0);
      lk1 = lookup(mPatt_1);
      match_0 = lk0[AW];
      match_1 = lk1[AW];
      mAddr_0 = lk0[AW] ? lk0[AW-1:0] : (mPatt_0[AW-1:0] ^ 6'h2A);
      mAddr_1 = lk1[AW] ? lk1[AW-1:0] : (mPatt_1[AW-1:0] ^ 6'h15);
   end

   typedef struct {
      logic [ID_W-1:0] id;
      logic            hit;
      logic [AW-1:0]   addr;
      int              rdy;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0, errors = 0, cyc = 0, pop_count = 0;
   logic acc0, acc1, popped;
   logic [ID_W-1:0] lp_id;
   logic lp_hit;
   logic [AW-1:0] lp_addr;
   int lp_cyc;

   function automatic logic [WIDTH-1:0] pick_key();
      int r;
      r = int'($urandom_range(0, 2));
      if (r == 0) return {4'hF, 32'($urandom)};
      return cam_key[4 * int'($urandom_range(0, 15)) + 1];
   endfunction

   function automatic exp_t make_exp(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] k, input int c);
      exp_t e;
      logic [AW:0] r;
      r = lookup(k);
      e.id = id;
      e.hit = r[AW];
      e.addr = r[AW-1:0];
      e.rdy = c + 3;
      return e;
   endfunction

   // One clock cycle: observe at the falling edge, update the scoreboard,
   // then advance to the next falling edge.
   task automatic step();
      exp_t e;
      int n_out;
      logic exp_valid;
      #1;
      n_out = exp_q.size();
      checks++;
      if (req_ready_0 !== (n_out < FIFO_DEPTH) || req_ready_1 !== (n_out <= FIFO_DEPTH - 2)) begin
         errors++;
         $display("FAIL ready cyc=%0d: got r0=%b r1=%b, need r0=%b r1=%b (outstanding %0d)",
                  cyc, req_ready_0, req_ready_1, n_out < FIFO_DEPTH, n_out <= FIFO_DEPTH - 2, n_out);
      end
      exp_valid = (n_out > 0) && (exp_q[0].rdy <= cyc);
      checks++;
      if (resp_valid !== exp_valid) begin
         errors++;
         $display("FAIL resp_valid cyc=%0d: got %b need %b", cyc, resp_valid, exp_valid);
      end
      popped = 1'b0;
      if (resp_valid === 1'b1 && resp_ready) begin
         popped = 1'b1;
         pop_count++;
         lp_id = resp_id; lp_hit = resp_hit; lp_addr = resp_addr; lp_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_resp cyc=%0d: got id=%0d hit=%b addr=%0d, need none", cyc, resp_id, resp_hit, resp_addr);
         end else begin
            e = exp_q.pop_front();
            if (resp_id !== e.id || resp_hit !== e.hit || resp_addr !== e.addr) begin
               errors++;
               $display("FAIL resp_data cyc=%0d: got id=%0d hit=%b addr=%0d, need id=%0d hit=%b addr=%0d",
                        cyc, resp_id, resp_hit, resp_addr, e.id, e.hit, e.addr);
            end
         end
      end
      acc0 = req_valid_0 && (n_out < FIFO_DEPTH);
      acc1 = acc0 && req_valid_1 && (n_out <= FIFO_DEPTH - 2);
      if (acc0) exp_q.push_back(make_exp(req_id_0, req_key_0, cyc));
      if (acc1) exp_q.push_back(make_exp(req_id_1, req_key_1, cyc));
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_pop(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         step();
         ok = popped;
      end
   endtask

   task automatic drain();
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding, need 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b1 || resp_valid !== 1'b0 || resp_id !== '0 ||
          resp_hit !== 1'b0 || resp_addr !== '0 || mPatt_0 !== '0 || mPatt_1 !== '0) begin
         errors++;
         $display("FAIL reset_state: got r0=%b r1=%b rv=%b id=%0d hit=%b addr=%0d p0=%h p1=%h, need 1 1 0 0 0 0 0 0",
                  req_ready_0, req_ready_1, resp_valid, resp_id, resp_hit, resp_addr, mPatt_0, mPatt_1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int t0;
      bit ok;
      resp_ready = 1'b1;
      req_valid_0 = 1'b1; req_key_0 = 36'h0_0000_00AB; req_id_0 = 4'd3;
      t0 = cyc;
      step();
      req_valid_0 = 1'b0;
      checks++;
      if (acc0 !== 1'b1) begin errors++; $display("FAIL single_accept: got %b need 1", acc0); end
      wait_pop(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout: got no response, need one");
      end else if (lp_cyc - t0 != 3 || lp_id !== 4'd3 || lp_hit !== 1'b1 || lp_addr !== 6'd5) begin
         errors++;
         $display("FAIL single_resp: got lat=%0d id=%0d hit=%b addr=%0d, need lat=3 id=3 hit=1 addr=5",
                  lp_cyc - t0, lp_id, lp_hit, lp_addr);
      end
   endtask

   task automatic test_dual_miss_hit();
      int t0;
      bit ok;
      resp_ready = 1'b1;
      req_valid_0 = 1'b1; req_key_0 = 36'h111; req_id_0 = 4'd1;
      req_valid_1 = 1'b1; req_key_1 = 36'hAB;  req_id_1 = 4'd2;
      t0 = cyc;
      step();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      wait_pop(10, ok);
      checks++;
      if (!ok || lp_cyc - t0 != 3 || lp_id !== 4'd1 || lp_hit !== 1'b0 || lp_addr !== '0) begin
         errors++;
         $display("FAIL dual_first: got ok=%b lat=%0d id=%0d hit=%b addr=%0d, need lat=3 id=1 hit=0 addr=0",
                  ok, lp_cyc - t0, lp_id, lp_hit, lp_addr);
      end
      wait_pop(3, ok);
      checks++;
      if (!ok || lp_cyc - t0 != 4 || lp_id !== 4'd2 || lp_hit !== 1'b1 || lp_addr !== 6'd5) begin
         errors++;
         $display("FAIL dual_second: got ok=%b lat=%0d id=%0d hit=%b addr=%0d, need lat=4 id=2 hit=1 addr=5",
                  ok, lp_cyc - t0, lp_id, lp_hit, lp_addr);
      end
   endtask

   task automatic test_backpressure();
      int n_acc, p0;
      resp_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         req_valid_0 = 1'b1; req_key_0 = pick_key(); req_id_0 = ID_W'(2 * i);
         req_valid_1 = 1'b1; req_key_1 = pick_key(); req_id_1 = ID_W'(2 * i + 1);
         step();
         n_acc += int'(acc0) + int'(acc1);
      end
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      checks++;
      if (n_acc != FIFO_DEPTH || req_ready_0 !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: got accepted=%0d ready0=%b, need accepted=%0d ready0=0", n_acc, req_ready_0, FIFO_DEPTH);
      end
      p0 = pop_count;
      resp_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
      checks++;
      if (pop_count - p0 != FIFO_DEPTH || req_ready_0 !== 1'b1 || req_ready_1 !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got pops=%0d r0=%b r1=%b, need pops=%0d r0=1 r1=1",
                  pop_count - p0, req_ready_0, req_ready_1, FIFO_DEPTH);
      end
   endtask

   task automatic test_partial_credit();
      logic [WIDTH-1:0] held_key;
      logic [ID_W-1:0] held_id;
      resp_ready = 1'b0;
      req_valid_1 = 1'b0;
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
         req_valid_0 = 1'b1; req_key_0 = pick_key(); req_id_0 = ID_W'(i);
         step();
      end
      req_valid_0 = 1'b1; req_key_0 = pick_key(); req_id_0 = 4'd7;
      held_key = 36'hAB; held_id = 4'd8;
      req_valid_1 = 1'b1; req_key_1 = held_key; req_id_1 = held_id;
      #1;
      checks++;
      if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
         errors++;
         $display("FAIL partial_ready: got r0=%b r1=%b, need r0=1 r1=0", req_ready_0, req_ready_1);
      end
      step();
      checks++;
      if (acc0 !== 1'b1 || acc1 !== 1'b0) begin
         errors++;
         $display("FAIL partial_accept: got a0=%b a1=%b, need a0=1 a1=0", acc0, acc1);
      end
      // Lane 1 alone must not be taken even with credit available
      req_valid_0 = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      req_valid_1 = 1'b0;
      req_valid_0 = 1'b1; req_key_0 = held_key; req_id_0 = held_id;
      for (int i = 0; i < 20; i++) begin
         step();
         if (acc0) break;
      end
      drain();
   endtask

   task automatic test_wrap();
      int p0;
      p0 = pop_count;
      req_valid_1 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         req_valid_0 = 1'b1; req_key_0 = pick_key(); req_id_0 = ID_W'(k % 16);
         for (int i = 0; i < 50; i++) begin
            resp_ready = 1'($urandom_range(0, 1));
            step();
            if (acc0) break;
         end
      end
      drain();
      checks++;
      if (pop_count - p0 != 20) begin
         errors++;
         $display("FAIL wrap_count: got %0d responses, need 20", pop_count - p0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         req_valid_0 = 1'($urandom_range(0, 1)); req_key_0 = pick_key(); req_id_0 = ID_W'($urandom);
         req_valid_1 = 1'($urandom_range(0, 1)); req_key_1 = pick_key(); req_id_1 = ID_W'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      int t0;
      bit ok;
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid_0 = 1'b1; req_key_0 = pick_key(); req_id_0 = ID_W'(i + 9);
         step();
      end
      req_valid_0 = 1'b0;
      step();
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL midflight_pre: got resp_valid=%b need 1", resp_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready_0 !== 1'b1 || req_ready_1 !== 1'b1 || mPatt_0 !== '0) begin
         errors++;
         $display("FAIL midflight_reset: got rv=%b r0=%b r1=%b p0=%h, need 0 1 1 0",
                  resp_valid, req_ready_0, req_ready_1, mPatt_0);
      end
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      resp_ready = 1'b1;
      req_valid_0 = 1'b1; req_key_0 = 36'hAB; req_id_0 = 4'd6;
      t0 = cyc;
      step();
      req_valid_0 = 1'b0;
      wait_pop(10, ok);
      checks++;
      if (!ok || lp_cyc - t0 != 3 || lp_id !== 4'd6 || lp_hit !== 1'b1 || lp_addr !== 6'd5) begin
         errors++;
         $display("FAIL midflight_after: got ok=%b lat=%0d id=%0d hit=%b addr=%0d, need lat=3 id=6 hit=1 addr=5",
                  ok, lp_cyc - t0, lp_id, lp_hit, lp_addr);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         cam_vld[i] = (i % 4 == 1);
         cam_key[i] = (i % 4 == 1) ? WIDTH'(36'h1000 + 37 * i) : '0;
      end
      cam_key[5] = 36'h0_0000_00AB;
      test_reset();
      test_single();
      test_dual_miss_hit();
      test_backpressure();
      test_partial_credit();
      test_wrap();
      test_random();
      test_reset_midflight();
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, need completion");
      $fatal(1);
   end

endmodule
